// File: rtl/cache_fill_fsm_if.sv
// Bundle between the cache miss handler, the pipeline stall input and main memory.
// The slave modport is the fill FSM; the master modport is its environment.
interface cache_fill_fsm_if #(
  parameter int ADDR_W = 16
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic [ADDR_W-1:0] memory_data;
  logic              memory_data_valid;
  logic              fsm_busy;
  logic              mem_en;
  logic [ADDR_W-1:0] memory_address;
  logic [ADDR_W-1:0] cache_addr;
  logic [ADDR_W-1:0] fill_data;
  logic              write_data_array;
  logic              write_tag_array;

  modport master (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  fsm_busy, mem_en, memory_address, cache_addr, fill_data,
           write_data_array, write_tag_array
  );

  modport slave (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output fsm_busy, mem_en, memory_address, cache_addr, fill_data,
           write_data_array, write_tag_array
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache block fill engine: streams one block of words from main memory into the
// data array with pipelined requests, then writes the tag/valid metadata once.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input logic             clk,
  input logic             rst,
  cache_fill_fsm_if.slave bus
);

  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0]  LAST       = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] VALID_BIT  = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    TAG
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] base, base_next;
  logic [CNT_W-1:0]  req_cnt, req_next;
  logic [CNT_W-1:0]  rcv_cnt, rcv_next;
  logic [OFF_W-1:0]  req_off;

  function automatic logic [ADDR_W-1:0] byte_off(input logic [OFF_W-1:0] idx);
    return ADDR_W'({idx, 1'b0});
  endfunction

  // Once all requests are out, memory_address parks on the last word issued.
  assign req_off = (req_cnt >= LAST) ? OFF_W'(WORDS_PER_BLOCK - 1) : req_cnt[OFF_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block below.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      base    <= '0;
      req_cnt <= '0;
      rcv_cnt <= '0;
    end else begin
      state   <= state_next;
      base    <= base_next;
      req_cnt <= req_next;
      rcv_cnt <= rcv_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next           = state;
    base_next            = base;
    req_next             = req_cnt;
    rcv_next             = rcv_cnt;
    bus.fsm_busy         = 1'b0;
    bus.mem_en           = 1'b0;
    bus.memory_address   = '0;
    bus.cache_addr       = '0;
    bus.fill_data        = '0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;

    unique case (state)
      IDLE: begin
        // Stall goes out in the same cycle as the miss.
        if (bus.miss_detected) begin
          bus.fsm_busy = 1'b1;
          base_next    = bus.miss_address & BLOCK_MASK;
          req_next     = '0;
          rcv_next     = '0;
          state_next   = FILL;
        end
      end

      FILL: begin
        bus.fsm_busy       = 1'b1;
        bus.memory_address = base + byte_off(req_off);
        if (req_cnt < LAST) begin
          bus.mem_en = 1'b1;
          req_next   = req_cnt + 1'b1;
        end
        // Returns are accepted independently of the request side.
        if (bus.memory_data_valid && (rcv_cnt < LAST)) begin
          bus.write_data_array = 1'b1;
          bus.cache_addr       = base + byte_off(rcv_cnt[OFF_W-1:0]);
          bus.fill_data        = bus.memory_data;
          rcv_next             = rcv_cnt + 1'b1;
          if (rcv_cnt == LAST - 1'b1) state_next = TAG;
        end
      end

      TAG: begin
        bus.fsm_busy        = 1'b1;
        bus.write_tag_array = 1'b1;
        bus.memory_address  = base + byte_off(req_off);
        bus.cache_addr      = base | VALID_BIT;
        state_next          = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
